// File: rtl/wide_add_sequencer.sv
// Multi-precision adder/subtractor: time-shares one 32-bit adder over WORDS slices,
// least-significant slice first, carrying between slices through a register.

module ripple_adder32 (
  input  logic        c_in,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [32:0] w_total;

  assign w_total = {1'b0, A} + {1'b0, B} + {32'd0, c_in};
  assign sum     = w_total[31:0];
  assign c_out   = w_total[32];
endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic [32*WORDS-1:0] a_in,
  input  logic [32*WORDS-1:0] b_in,
  output logic              busy,
  output logic              done,
  output logic [32*WORDS-1:0] result,
  output logic              c_out,
  output logic              ovf
);
  localparam int W = 32 * WORDS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [W-1:0]     r_result;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [31:0]      w_slice_a;
  logic [31:0]      w_slice_b;
  logic [31:0]      w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_slice_a = r_op_a[r_idx*32 +: 32];
  assign w_slice_b = r_op_b[r_idx*32 +: 32];
  assign w_last    = (r_idx == IDX_W'(WORDS - 1));

  ripple_adder32 u_adder (
    .c_in  (r_carry),
    .A     (w_slice_a),
    .B     (w_slice_b),
    .sum   (w_sum),
    .c_out (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
            r_op_a  <= a_in;
            r_op_b  <= sub ? ~b_in : b_in;
            r_carry <= sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_result[r_idx*32 +: 32] <= w_sum;
          r_carry                  <= w_cout;
          if (w_last) begin
            r_c_out <= w_cout;
            r_ovf   <= (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[31] != r_op_a[W-1]);
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign c_out  = r_c_out;
  assign ovf    = r_ovf;
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle, multi-precision adder/subtractor controller.
- Performs WORDS×32-bit addition or subtraction by time-sharing one instance of the team's 32-bit ripple adder (ports c_in, sum, A, B, c_out).
- Processes one 32-bit slice per cycle, least-significant first, with the carry held in a register between slices.
- Sits beside the ALU datapath; gives wide arithmetic without replicating adder hardware.

Parameters:
- WORDS, 4, number of 32-bit slices; operand width W = 32*WORDS; legal range 2..16.
- IDX_W, 2, slice index counter width; must satisfy 2**IDX_W >= WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A−B; latched on accept.
- a_in  input  W  operand A; latched on accept.
- b_in  input  W  operand B; latched on accept.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  W  sum or difference.
- c_out  output  1  final carry out; for sub, 1 = no borrow.
- ovf  output  1  signed two's-complement overflow of the W-bit result.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state ← IDLE; idx, carry, and the operand registers ← 0.
  - result ← 0, c_out ← 0, ovf ← 0, busy ← 0, done ← 0.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge is accepted: a_in → opA; b_in, or ~b_in when sub=1, → opB; carry ← sub; idx ← 0; state ← RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - Each edge, adder inputs are A = opA[idx], B = opB[idx], c_in = carry.
  - result slice idx ← adder sum; carry ← adder c_out; idx ← idx+1.
  - On the edge where idx = WORDS−1:
    - c_out ← adder c_out.
    - ovf ← (opA msb == opB msb) && (sum msb != opA msb).
    - state ← DONE.
  - start is ignored in RUN; in-flight operands are never disturbed.
- DONE (done=1 for exactly one cycle, busy=0):
  - start=1: accepted exactly as in IDLE, giving back-to-back operation; next state is RUN.
  - start=0: next state is IDLE.
- Latency: start accepted at edge k → busy during cycles k+1..k+WORDS → done=1 during cycle k+WORDS+1. Throughput is one operation per WORDS+1 cycles.
- Output validity:
  - result, c_out, and ovf are valid while done=1 and stay stable until the next accepted start.
  - During RUN, result slices update progressively; lower slices hold new data, upper slices hold the previous result. Consumers must not sample result during RUN.
- Arithmetic:
  - Modulo 2**W; no saturation.
  - The carry chain propagates across all slices through the carry register only; there is no combinational path between slices.
- idx counts 0..WORDS−1 only and never wraps inside RUN.
- start held high continuously → one operation every WORDS+1 cycles, with operands re-sampled at each DONE.

Test Plan (WORDS=4, W=128):
1. Carry across all slices: A=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, sub=0, start pulse.
   - busy high for 4 cycles, then done.
   - result=0x0000_0001_0000_0000_0000_0000_0000_0000, c_out=0, ovf=0.
2. Carry out and unsigned wrap: A=all-ones, B=1, sub=0.
   - result=0, c_out=1, ovf=0.
3. Subtraction with borrow: A=5, B=7, sub=1.
   - result=0xFFFF_…_FFFE, c_out=0, ovf=0.
   - With A=7, B=5: result=2, c_out=1.
4. Signed overflow: A=0x7FFF_…_FFFF, B=1, sub=0.
   - result=0x8000_…_0000, ovf=1, c_out=0.
5. Ignored start and back-to-back:
   - Pulse start with new operands during RUN → first result is unaffected.
   - Assert start during DONE with A=3, B=4 → busy next cycle, done 5 cycles after the first done, result=7.
6. Reset mid-RUN: assert rst on the 2nd RUN cycle.
   - Next cycle: busy=0, done=0, result=0, c_out=0, ovf=0.
   - No done pulse follows; a subsequent start operates normally.
